// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall and forwarding controller for the five-stage MIPS pipeline
// Optional HI/LO busy tracking is built when HAZARD_MDU_EN is defined.
module hazard_unit #(
  parameter int MDU_MULT_CYCLES = 5,
  parameter int MDU_DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [2:0] D_Tuse_A1,
  input  logic [2:0] D_Tuse_A2,
  input  logic [4:0] D_A3,
  input  logic [2:0] D_Tnew,
  output logic       stall,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
  output logic [1:0] fwd_M_rt
`ifdef HAZARD_MDU_EN
  ,
  input  logic       D_md_use,
  input  logic [1:0] D_md_start,
  output logic       md_busy
`endif
);

  localparam logic [4:0] MULT_LD = 5'(MDU_MULT_CYCLES);
  localparam logic [4:0] DIV_LD  = 5'(MDU_DIV_CYCLES);

  logic [4:0] E_A3_q, E_A3_d, E_rs_q, E_rs_d, E_rt_q, E_rt_d;
  logic [2:0] E_Tnew_q, E_Tnew_d;
  logic [4:0] M_A3_q, M_A3_d, M_rt_q, M_rt_d;
  logic [2:0] M_Tnew_q, M_Tnew_d;
  logic [4:0] W_A3_q, W_A3_d;
  logic [2:0] W_Tnew_q, W_Tnew_d;
  logic       reg_stall;

  function automatic logic hz(input logic [4:0] src, input logic [2:0] tuse,
                              input logic [4:0] a3, input logic [2:0] tnew);
    return (src != 5'd0) && (src == a3) && (tuse < tnew);
  endfunction

  // Youngest matching stage wins; a winner still in flight yields 0 rather than an older copy.
  function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                          input logic e_ok, input logic [4:0] e_a3, input logic [2:0] e_tnew,
                                          input logic m_ok, input logic [4:0] m_a3, input logic [2:0] m_tnew,
                                          input logic [4:0] w_a3, input logic [2:0] w_tnew);
    if (src == 5'd0)                return 2'd0;
    if (e_ok && src == e_a3)        return (e_tnew == 3'd0) ? 2'd1 : 2'd0;
    if (m_ok && src == m_a3)        return (m_tnew == 3'd0) ? 2'd2 : 2'd0;
    if (src == w_a3)                return (w_tnew == 3'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  always_comb begin
    reg_stall = hz(D_rs, D_Tuse_A1, E_A3_q, E_Tnew_q) | hz(D_rs, D_Tuse_A1, M_A3_q, M_Tnew_q) |
                hz(D_rt, D_Tuse_A2, E_A3_q, E_Tnew_q) | hz(D_rt, D_Tuse_A2, M_A3_q, M_Tnew_q);
  end

  always_comb begin
    fwd_D_rs = fwd_pick(D_rs, 1'b1, E_A3_q, E_Tnew_q, 1'b1, M_A3_q, M_Tnew_q, W_A3_q, W_Tnew_q);
    fwd_D_rt = fwd_pick(D_rt, 1'b1, E_A3_q, E_Tnew_q, 1'b1, M_A3_q, M_Tnew_q, W_A3_q, W_Tnew_q);
    fwd_E_rs = fwd_pick(E_rs_q, 1'b0, 5'd0, 3'd0, 1'b1, M_A3_q, M_Tnew_q, W_A3_q, W_Tnew_q);
    fwd_E_rt = fwd_pick(E_rt_q, 1'b0, 5'd0, 3'd0, 1'b1, M_A3_q, M_Tnew_q, W_A3_q, W_Tnew_q);
    fwd_M_rt = fwd_pick(M_rt_q, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, W_A3_q, W_Tnew_q);
  end

`ifdef HAZARD_MDU_EN
  logic [1:0] E_md_start_q, E_md_start_d;
  logic [4:0] md_cnt_q, md_cnt_d;

  assign stall   = reg_stall | (D_md_use & ((E_md_start_q != 2'd0) | (md_cnt_q != 5'd0)));
  assign md_busy = (md_cnt_q != 5'd0);

  always_comb begin
    E_md_start_d = stall ? 2'd0 : D_md_start;
    case (E_md_start_q)
      2'b01:   md_cnt_d = MULT_LD;
      2'b10:   md_cnt_d = DIV_LD;
      default: md_cnt_d = (md_cnt_q != 5'd0) ? md_cnt_q - 5'd1 : 5'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_md_start_q <= 2'd0;
      md_cnt_q     <= 5'd0;
    end else begin
      E_md_start_q <= E_md_start_d;
      md_cnt_q     <= md_cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MULT_LD, DIV_LD};
  assign stall      = reg_stall;
`endif

  // A stalled D instruction stays put and E receives a bubble.
  always_comb begin
    E_A3_d   = stall ? 5'd0 : D_A3;
    E_Tnew_d = stall ? 3'd0 : D_Tnew;
    E_rs_d   = stall ? 5'd0 : D_rs;
    E_rt_d   = stall ? 5'd0 : D_rt;
    M_A3_d   = E_A3_q;
    M_Tnew_d = (E_Tnew_q == 3'd0) ? 3'd0 : E_Tnew_q - 3'd1;
    M_rt_d   = E_rt_q;
    W_A3_d   = M_A3_q;
    W_Tnew_d = 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_A3_q   <= 5'd0;
      E_Tnew_q <= 3'd0;
      E_rs_q   <= 5'd0;
      E_rt_q   <= 5'd0;
      M_A3_q   <= 5'd0;
      M_Tnew_q <= 3'd0;
      M_rt_q   <= 5'd0;
      W_A3_q   <= 5'd0;
      W_Tnew_q <= 3'd0;
    end else begin
      E_A3_q   <= E_A3_d;
      E_Tnew_q <= E_Tnew_d;
      E_rs_q   <= E_rs_d;
      E_rt_q   <= E_rt_d;
      M_A3_q   <= M_A3_d;
      M_Tnew_q <= M_Tnew_d;
      M_rt_q   <= M_rt_d;
      W_A3_q   <= W_A3_d;
      W_Tnew_q <= W_Tnew_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector bench for hazard_unit
// MDU sequences are exercised only when HAZARD_MDU_EN is defined.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [2:0] D_Tuse_A1, D_Tuse_A2, D_Tnew;
  logic       stall;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
`ifdef HAZARD_MDU_EN
  logic       D_md_use;
  logic [1:0] D_md_start;
  logic       md_busy;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_A1(D_Tuse_A1), .D_Tuse_A2(D_Tuse_A2),
    .D_A3(D_A3), .D_Tnew(D_Tnew),
    .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
`ifdef HAZARD_MDU_EN
    , .D_md_use(D_md_use), .D_md_start(D_md_start), .md_busy(md_busy)
`endif
  );

  typedef struct {
    int rs, rt, tu1, tu2, a3, tnew;
    int stall, fdrs, fdrt, fers, fert, fmrt;
  } vec_t;

  vec_t tv[28];

  function automatic vec_t mk(int rs, int rt, int tu1, int tu2, int a3, int tnew,
                              int st, int fdrs, int fdrt, int fers, int fert, int fmrt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.tu1 = tu1; v.tu2 = tu2; v.a3 = a3; v.tnew = tnew;
    v.stall = st; v.fdrs = fdrs; v.fdrt = fdrt; v.fers = fers; v.fert = fert; v.fmrt = fmrt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(int rs, int rt, int tu1, int tu2, int a3, int tnew);
    D_rs = 5'(rs); D_rt = 5'(rt); D_Tuse_A1 = 3'(tu1); D_Tuse_A2 = 3'(tu2);
    D_A3 = 5'(a3); D_Tnew = 3'(tnew);
  endtask

  task automatic chk_all(string tag, int st, int fdrs, int fdrt, int fers, int fert, int fmrt);
    chk({tag, ".stall"},    int'(stall),    st);
    chk({tag, ".fwd_D_rs"}, int'(fwd_D_rs), fdrs);
    chk({tag, ".fwd_D_rt"}, int'(fwd_D_rt), fdrt);
    chk({tag, ".fwd_E_rs"}, int'(fwd_E_rs), fers);
    chk({tag, ".fwd_E_rt"}, int'(fwd_E_rt), fert);
    chk({tag, ".fwd_M_rt"}, int'(fwd_M_rt), fmrt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    //         rs  rt tu1 tu2 a3 tn   st dr dt er et mt
    tv[0]  = mk( 7,  7, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0);
    tv[1]  = mk(29,  0, 1, 5,  1, 2,   0, 0, 0, 0, 0, 0); // lw $1
    tv[2]  = mk( 1,  1, 1, 1,  2, 1,   1, 0, 0, 0, 0, 0); // addu $2,$1,$1
    tv[3]  = mk( 1,  1, 1, 1,  2, 1,   0, 0, 0, 0, 0, 0);
    tv[4]  = mk( 0,  0, 5, 5,  0, 0,   0, 0, 0, 3, 3, 0);
    tv[5]  = mk( 0,  0, 1, 5,  3, 1,   0, 0, 0, 0, 0, 0); // ori $3
    tv[6]  = mk( 3,  0, 0, 0,  0, 0,   1, 0, 0, 0, 0, 0); // beq $3,$0
    tv[7]  = mk( 3,  0, 0, 0,  0, 0,   0, 2, 0, 0, 0, 0);
    tv[8]  = mk( 0,  0, 5, 5, 31, 0,   0, 0, 0, 3, 0, 0); // jal
    tv[9]  = mk(31,  0, 0, 5,  0, 0,   0, 1, 0, 0, 0, 0); // jr $31
    tv[10] = mk( 0,  0, 1, 5,  0, 1,   0, 0, 0, 2, 0, 0); // ori $0
    tv[11] = mk( 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0); // beq $0,$0
    tv[12] = mk( 0,  0, 1, 5,  5, 1,   0, 0, 0, 0, 0, 0); // ori $5
    tv[13] = mk( 0,  0, 5, 5,  5, 0,   0, 0, 0, 0, 0, 0); // link into $5
    tv[14] = mk( 5,  0, 1, 5,  6, 1,   0, 1, 0, 0, 0, 0);
    tv[15] = mk( 0,  0, 1, 5,  5, 1,   0, 0, 0, 2, 0, 0); // ori $5
    tv[16] = mk( 5,  0, 1, 5,  0, 0,   0, 0, 0, 0, 0, 0);
    tv[17] = mk( 0,  0, 1, 5,  7, 2,   0, 0, 0, 2, 0, 0); // lw $7
    tv[18] = mk( 0,  0, 1, 5,  8, 2,   0, 0, 0, 0, 0, 0); // lw $8
    tv[19] = mk( 7,  8, 1, 1,  9, 1,   1, 0, 0, 0, 0, 0); // addu $9,$7,$8
    tv[20] = mk( 7,  8, 1, 1,  9, 1,   0, 3, 0, 0, 0, 0);
    tv[21] = mk( 0,  9, 1, 2,  0, 0,   0, 0, 0, 0, 3, 0); // sw $9
    tv[22] = mk( 0,  0, 5, 5,  0, 0,   0, 0, 0, 0, 2, 0);
    tv[23] = mk( 0,  0, 5, 5,  0, 0,   0, 0, 0, 0, 0, 3);
    tv[24] = mk( 0,  0, 1, 5, 10, 2,   0, 0, 0, 0, 0, 0); // lw $10
    tv[25] = mk(10,  0, 0, 0,  0, 0,   1, 0, 0, 0, 0, 0); // beq $10,$0
    tv[26] = mk(10,  0, 0, 0,  0, 0,   1, 0, 0, 0, 0, 0);
    tv[27] = mk(10,  0, 0, 0,  0, 0,   0, 3, 0, 0, 0, 0);

`ifdef HAZARD_MDU_EN
    D_md_use = 1'b0;
    D_md_start = 2'd0;
`endif
    drive(1, 1, 0, 0, 1, 2);
    reset = 1'b1;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(tv[i].rs, tv[i].rt, tv[i].tu1, tv[i].tu2, tv[i].a3, tv[i].tnew);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tv[i].stall, tv[i].fdrs, tv[i].fdrt,
              tv[i].fers, tv[i].fert, tv[i].fmrt);
      @(posedge clk); #1;
    end

    // asynchronous reset while a load-use stall is pending
    drive(0, 0, 1, 5, 1, 2);
    @(posedge clk); #1;
    drive(1, 1, 1, 1, 2, 1);
    @(negedge clk);
    chk("arst.pre_stall", int'(stall), 1);
    #1 reset = 1'b1;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 5, 5, 0, 0);

`ifdef HAZARD_MDU_EN
    // mult followed by mflo: six stall cycles, busy during the last five
    D_md_use = 1'b1; D_md_start = 2'b01;
    drive(1, 2, 1, 1, 0, 0);
    @(negedge clk);
    chk("mdu.mult_stall", int'(stall), 0);
    @(posedge clk); #1;
    D_md_start = 2'b00;
    drive(0, 0, 5, 5, 3, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("mdu.stall%0d", k), int'(stall), (k <= 6) ? 1 : 0);
      chk($sformatf("mdu.busy%0d", k), int'(md_busy), (k >= 2 && k <= 6) ? 1 : 0);
      @(posedge clk); #1;
    end
    D_md_use = 1'b0;
    drive(0, 0, 5, 5, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset while the counter is running
    D_md_use = 1'b1; D_md_start = 2'b10;
    drive(1, 2, 1, 1, 0, 0);
    @(posedge clk); #1;
    D_md_start = 2'b00;
    drive(0, 0, 5, 5, 3, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mdu.busy_mid", int'(md_busy), 1);
    chk("mdu.stall_mid", int'(stall), 1);
    #1 reset = 1'b1;
    #1;
    chk("mdu.rst_busy", int'(md_busy), 0);
    chk("mdu.rst_stall", int'(stall), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    D_md_use = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
